// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control front-end for the stopwatch counter. Two raw push-buttons are
// synchronized, optionally debounced and edge-detected into one-cycle presses.
// The presses drive an IDLE/RUN/PAUSE state machine. The block also runs a
// prescaler that emits a count tick every CLK_DIV clocks while running.
//
// Parameters:
//   CLK_DIV     clocks per count tick (>= 2)
//   DEB_CYCLES  consecutive stable clocks needed to accept a button level (>= 1)
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   btn_start_i  raw start/stop button, active-high, asynchronous
//   btn_rst_i    raw reset button, active-high, asynchronous
//   tick_o       one-cycle count tick for the counter's clk_timer
//   timer_en_o   high while in RUN (counter enable)
//   timer_rst_o  one-cycle counter-clear pulse
//   state_o      current state: 00 IDLE, 01 RUN, 10 PAUSE
//
// Build option:
//   STOPWATCH_DEBOUNCE_EN  when defined, builds the debounce stage. When it is
//                          undefined, the debounced level is the synchronized
//                          level and DEB_CYCLES has no effect.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int CLK_DIV    = 500000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_start_i,
  input  logic       btn_rst_i,
  output logic       tick_o,
  output logic       timer_en_o,
  output logic       timer_rst_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  if (CLK_DIV < 2 || DEB_CYCLES < 1) begin : g_bad_params
    $error("stopwatch_ctrl: requires CLK_DIV >= 2 and DEB_CYCLES >= 1");
  end

  // Index 0 is the start button and index 1 is the reset button.
  logic [1:0] sync_q0;
  logic [1:0] sync_q1;
  logic [1:0] deb_lvl;
  logic [1:0] deb_prev;
  logic       press_start;
  logic       press_rst;

  state_t        state;
  state_t        state_nxt;
  logic          clr_nxt;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q0 <= 2'b00;
      sync_q1 <= 2'b00;
    end else begin
      sync_q0 <= {btn_rst_i, btn_start_i};
      sync_q1 <= sync_q0;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt [2];

  // The level is accepted on the DEB_CYCLES-th consecutive edge that sees it
  // differ from the current debounced level. Any agreeing edge restarts the
  // count, so short glitches never propagate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      deb_lvl <= 2'b00;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_q1[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          deb_lvl[i] <= sync_q1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign deb_lvl = sync_q1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) deb_prev <= 2'b00;
    else       deb_prev <= deb_lvl;
  end

  // The edge detector is combinational so a press is acted on at the edge
  // right after the debounced level rises.
  assign press_start = deb_lvl[0] & ~deb_prev[0];
  assign press_rst   = deb_lvl[1] & ~deb_prev[1];

  // A reset press has priority whenever reset is meaningful (IDLE and PAUSE).
  // In RUN, the reset button is ignored, so a simultaneous start still pauses.
  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (press_rst)        clr_nxt   = 1'b1;
        else if (press_start) state_nxt = RUN;
      end
      RUN: begin
        if (press_start) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (press_rst) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
        end else if (press_start) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The enable and clear outputs are registered from the next-state decode so
  // they change on the same edge as the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      timer_en_o  <= 1'b0;
      timer_rst_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer_en_o  <= (state_nxt == RUN);
      timer_rst_o <= clr_nxt;
    end
  end

  assign state_o = state;

  // The prescaler advances on edges whose current state is RUN, which includes
  // the RUN->PAUSE edge. A pause that lands on the wrap edge still ticks, while
  // timer_en_o is already low. The prescaler is held in PAUSE so a resume
  // finishes the partial interval. It is cleared only when returning to IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      tick_o <= 1'b0;
    end else if (state == RUN) begin
      if (cnt == CNT_MAX) begin
        cnt    <= '0;
        tick_o <= 1'b1;
      end else begin
        cnt    <= cnt + 1'b1;
        tick_o <= 1'b0;
      end
    end else begin
      tick_o <= 1'b0;
      if (state_nxt == IDLE) cnt <= '0;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Bench for stopwatch_ctrl with CLK_DIV = 4 and DEB_CYCLES = 3. A table of
// button-hold records, each with its expected end state and pulse counts, is
// driven through a scoreboard queue. Hand-written sequences then cover press
// latency, first-tick spacing, a glitch, and an asynchronous reset mid-run.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int CLK_DIV    = 4;
  localparam int DEB_CYCLES = 3;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT          = DEB_CYCLES;
  localparam int GLITCH_ST    = 0;
  localparam int GLITCH_TICKS = 0;
`else
  localparam int LAT          = 0;
  localparam int GLITCH_ST    = 1;
  localparam int GLITCH_TICKS = 2;
`endif
  // Edge, counted from the raw rise, at which a press changes the state.
  localparam int P = 3 + LAT;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  logic       clk = 1'b0;
  logic       rstn;
  logic       btn_start_i;
  logic       btn_rst_i;
  logic       tick_o;
  logic       timer_en_o;
  logic       timer_rst_o;
  logic [1:0] state_o;

  stopwatch_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .btn_start_i (btn_start_i),
    .btn_rst_i   (btn_rst_i),
    .tick_o      (tick_o),
    .timer_en_o  (timer_en_o),
    .timer_rst_o (timer_rst_o),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // One record holds the buttons for n edges. It gives the state and enable
  // expected after the last edge, plus the number of tick pulses, clear
  // pulses and ticks seen with the enable low. It also gives the edge index
  // of the first tick (0 when there is none).
  typedef struct {
    logic       start;
    logic       rst;
    int         n;
    logic [1:0] st;
    logic       en;
    int         ticks;
    int         rsts;
    int         toff;
    int         first;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   run_pos  = 0;

  // Ticks land on every CLK_DIV-th edge spent in RUN since leaving IDLE.
  function automatic int ticksIn(input int a, input int n);
    return (a + n) / CLK_DIV - a / CLK_DIV;
  endfunction

  function automatic int firstTick(input int a, input int n);
    for (int k = 1; k <= n; k++)
      if ((a + k) % CLK_DIV == 0) return k;
    return 0;
  endfunction

  function automatic void addVec(input logic s, input logic r, input int n,
                                 input logic [1:0] st, input logic en,
                                 input int ticks, input int rsts,
                                 input int toff, input int first);
    vec_t v;
    v.start = s; v.rst = r; v.n = n; v.st = st; v.en = en;
    v.ticks = ticks; v.rsts = rsts; v.toff = toff; v.first = first;
    vecs.push_back(v);
  endfunction

  // Adds a record whose n edges all begin in RUN and advances the run position.
  function automatic void addRun(input logic s, input logic r, input int n,
                                 input logic [1:0] st, input logic en,
                                 input int toff);
    addVec(s, r, n, st, en, ticksIn(run_pos, n), 0, toff, firstTick(run_pos, n));
    run_pos += n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output vec_t got);
    sb_q.push_back(v);
    got = v;
    got.ticks = 0; got.rsts = 0; got.toff = 0; got.first = 0;
    btn_start_i = v.start;
    btn_rst_i   = v.rst;
    for (int k = 1; k <= v.n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (tick_o === 1'b1) begin
        got.ticks++;
        if (got.first == 0) got.first = k;
        if (timer_en_o !== 1'b1) got.toff++;
      end
      if (timer_rst_o === 1'b1) got.rsts++;
    end
    got.st = state_o;
    got.en = timer_en_o;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t got;
    vec_t exp;
    int   edges;
    int   nt;

    rstn        = 1'b0;
    btn_start_i = 1'b0;
    btn_rst_i   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", state_o, S_IDLE);
    checkOutput("reset_tick", tick_o, 0);
    checkOutput("reset_en", timer_en_o, 0);
    checkOutput("reset_clr", timer_rst_o, 0);
    rstn = 1'b1;

    // Each press is followed by a release that pads the pair to 12 edges. This
    // gives the debounced level time to fall before the next press.
    addVec(0, 1, P,      S_IDLE, 0, 0, 1, 0, 0);   // reset press in IDLE
    addVec(0, 0, 12 - P, S_IDLE, 0, 0, 0, 0, 0);
    addVec(1, 0, P,      S_RUN,  1, 0, 0, 0, 0);   // start
    run_pos = 0;
    addRun(0, 0, 12 - P, S_RUN,   1, 0);
    addRun(0, 1, P,      S_RUN,   1, 0);           // reset ignored in RUN
    addRun(0, 0, 12 - P, S_RUN,   1, 0);
    addRun(0, 0, 2,      S_RUN,   1, 0);
    addRun(1, 0, P,      S_PAUSE, 0, 0);           // pause mid-interval
    addVec(0, 0, 12 - P, S_PAUSE, 0, 0, 0, 0, 0);
    addVec(1, 0, P,      S_RUN,   1, 0, 0, 0, 0);  // resume
    addRun(0, 0, 12 - P, S_RUN,   1, 0);
    addRun(0, 0, 2,      S_RUN,   1, 0);
    addRun(1, 0, P,      S_PAUSE, 0, 1);           // pause on the wrap edge
    addVec(0, 0, 12 - P, S_PAUSE, 0, 0, 0, 0, 0);
    addVec(1, 0, P,      S_RUN,   1, 0, 0, 0, 0);
    addRun(0, 0, 12 - P, S_RUN,   1, 0);
    addRun(0, 0, 1,      S_RUN,   1, 0);
    addRun(1, 0, P,      S_PAUSE, 0, 0);           // pause with cnt = 1
    addVec(0, 0, 12 - P, S_PAUSE, 0, 0, 0, 0, 0);
    addVec(1, 1, P,      S_IDLE,  0, 0, 1, 0, 0);  // both pressed: reset wins
    addVec(0, 0, 12 - P, S_IDLE,  0, 0, 0, 0, 0);
    addVec(1, 0, P,      S_RUN,   1, 0, 0, 0, 0);
    run_pos = 0;
    addRun(0, 0, 3,      S_RUN,   1, 0);           // no early tick: cnt was cleared
    addRun(0, 0, 1,      S_RUN,   1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], got);
      exp = sb_q.pop_front();
      checkOutput($sformatf("rec%0d_state", i), got.st, exp.st);
      checkOutput($sformatf("rec%0d_en", i), got.en, exp.en);
      checkOutput($sformatf("rec%0d_ticks", i), got.ticks, exp.ticks);
      checkOutput($sformatf("rec%0d_first_tick", i), got.first, exp.first);
      checkOutput($sformatf("rec%0d_clr_pulses", i), got.rsts, exp.rsts);
      checkOutput($sformatf("rec%0d_ticks_en_low", i), got.toff, exp.toff);
    end

    // Asynchronous reset in the middle of RUN clears the outputs without a clock.
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_state", state_o, S_IDLE);
    checkOutput("async_rst_tick", tick_o, 0);
    checkOutput("async_rst_en", timer_en_o, 0);
    checkOutput("async_rst_clr", timer_rst_o, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Exact press latency, then the first tick CLK_DIV edges after RUN entry.
    btn_start_i = 1'b1;
    edges = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end while (state_o !== S_RUN && edges < 20);
    checkOutput("press_latency", edges, P);
    checkOutput("press_latency_en", timer_en_o, 1);
    btn_start_i = 1'b0;
    edges = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end while (tick_o !== 1'b1 && edges < 20);
    checkOutput("first_tick_spacing", edges, CLK_DIV);

    // A two-cycle glitch is rejected when debounced and accepted when not.
    pulseReset();
    btn_start_i = 1'b1;
    repeat (2) @(negedge clk);
    btn_start_i = 1'b0;
    nt = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (tick_o === 1'b1) nt++;
    end
    checkOutput("glitch_state", state_o, GLITCH_ST);
    checkOutput("glitch_ticks", nt, GLITCH_TICKS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control front-end for the stopwatch counter block. Synchronizes and (optionally) debounces two raw push-buttons, runs an IDLE/RUN/PAUSE state machine, and generates the counter's inputs:
- a 1-cycle count tick every CLK_DIV clocks;
- a run-enable level;
- a 1-cycle counter-clear pulse.

It sits between the board buttons and the stopwatch counter, on the same clk/rstn domain.

## Interface
- CLK_DIV, 500000, clocks per count tick (100 Hz at 50 MHz); legal ≥ 2.
- DEB_CYCLES, 1000000, consecutive stable clocks required to accept a button level change; legal ≥ 1.

- clk  input  1  system clock.
- rstn  input  1  reset, asynchronous, active-low.
- btn_start_i  input  1  raw start/stop button, active-high, asynchronous.
- btn_rst_i  input  1  raw reset button, active-high, asynchronous.
- tick_o  output  1  1-cycle count tick; drives counter clk_timer.
- timer_en_o  output  1  high while in RUN; drives counter enable.
- timer_rst_o  output  1  1-cycle counter-clear pulse.
- state_o  output  2  current state: 00 IDLE, 01 RUN, 10 PAUSE.

## Operation
- Each button passes through a 2-flop synchronizer, then the debounce stage, then a rising-edge detector. The detector output is a 1-cycle press (`press_start`, `press_rst`).
- Debounce stage:
  - The debounced level `d` changes only after the synchronized level differs from `d` for DEB_CYCLES consecutive edges.
  - Any edge where they agree clears the counter.
  - Counter width is $clog2(DEB_CYCLES+1).
- FSM transitions:
  - IDLE: `press_start` → RUN. `press_rst` → stay in IDLE and pulse timer_rst_o.
  - RUN: `press_start` → PAUSE. `press_rst` is ignored.
  - PAUSE: `press_rst` → IDLE and pulse timer_rst_o. Otherwise `press_start` → RUN.
  - Simultaneous presses in IDLE or PAUSE: reset wins; the start press is discarded.
  - Simultaneous presses in RUN: start wins.
- Prescaler `cnt`, width $clog2(CLK_DIV):
  - Increments on every edge at which the state is RUN.
  - At an edge where the state is RUN and `cnt == CLK_DIV-1`: `cnt` ← 0 and tick_o ← 1.
  - Held (not cleared) in PAUSE.
  - Cleared to 0 on entry to IDLE.
- Button levels held high produce exactly one press; repress requires release, debounced.

## Timing
- Reset values: state_o = 00, tick_o = 0, timer_en_o = 0, timer_rst_o = 0, `cnt` = 0, debounced levels = 0, synchronizers = 0.
- All outputs are registered.
- Press latency:
  - Raw input rises before edge 1.
  - Synchronized level changes at edge 2.
  - `d` changes at edge 2+DEB_CYCLES.
  - state_o, timer_en_o and timer_rst_o update at edge 3+DEB_CYCLES.
- timer_en_o changes on the same edge as state_o.
- timer_rst_o is high for exactly the one cycle following the edge that performs the reset action.
- Tick spacing:
  - In continuous RUN, tick_o is high one cycle in every CLK_DIV.
  - From IDLE, the first tick follows CLK_DIV edges after the RUN-entry edge.
  - After PAUSE → RUN, the remaining partial interval is preserved.
- Pause on a tick edge: if the RUN→PAUSE edge coincides with `cnt == CLK_DIV-1`, tick_o still pulses and `cnt` wraps to 0. timer_en_o is already low, so the counter does not count that tick.
- tick_o is never high in IDLE or PAUSE except for the single pulse described above.
- Asynchronous reset mid-operation (including mid-debounce or mid-tick) returns everything to the reset values immediately. No pulse is emitted.

## Configuration
- STOPWATCH_DEBOUNCE_EN:
  - Defined: the debounce stage is built as described.
  - Undefined: the debounce stage and its counters are removed; `d` equals the synchronized level, DEB_CYCLES is unused, and press latency becomes edge 3.
  - All other behaviour is identical.

## Test plan
- All scenarios use CLK_DIV = 4, DEB_CYCLES = 3, with the macro defined unless noted.
- Reset, then press start (held 10 cycles) → state_o = 01 at edge 6 after the rise; tick_o pulses 4, 8, 12 edges later; timer_en_o = 1.
- Glitch: btn_start_i high for 2 cycles then low → no state change, no tick.
- RUN, press reset → ignored. Press start → PAUSE with `cnt` preserved. Resume start → next tick arrives after the remaining interval, not after 4 clocks.
- PAUSE, press start and reset in the same cycle → IDLE; timer_rst_o high for 1 cycle; `cnt` = 0; timer_en_o = 0.
- Pause timed so the RUN→PAUSE edge hits `cnt = 3` → tick_o pulses once while timer_en_o = 0; no further ticks in PAUSE.
- Macro undefined: press start → state_o = 01 at edge 3. Assert rstn low mid-RUN → all outputs 0 at once.
